// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory read responder.
//   - Response codes (same encoding as the instruction cache's INST_* codes).
//   - Responder FSM state encoding.
//   - LFSR seed and tap mask used by the optional random-delay mode.
//   - decode_resp(): address-to-response decode shared by the AR path.
package imem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h5A;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Range check first (DECERR), then alignment (SLVERR), else OKAY.
  // The offset is computed in 33 bits so an address below base cannot wrap
  // into range and base+span cannot overflow.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    if ((addr < base) || (off >= span)) return RESP_DECERR;
    else if (addr[1:0] != 2'b00)        return RESP_SLVERR;
    else                                return RESP_OKAY;
  endfunction

endpackage

// File: rtl/imem_rd_responder_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), loaded with LFSR_SEED on reset,
// advances one step per cycle while en_i is high.
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   en_i          - step enable
//   lfsr_o        - current LFSR value
module lfsr8
  import imem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/imem_rd_responder.sv
// imem_rd_responder: single-outstanding read responder for the instruction
// fetch bus, backed by a word-addressed memory with a backdoor preload port.
// An accepted AR is decoded immediately; after the configured delay the word
// (or zero for error responses) is returned as one R beat held until rready.
//
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   arvalid_i/araddr_i    - read address request (byte address)
//   arready_o             - high in IDLE (low while reset is asserted)
//   rvalid_o/rdata_o/rresp_o, rready_i - read data beat
//   bd_wen_i/bd_waddr_i/bd_wdata_i     - backdoor word write (out of range ignored)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the responder holds rvalid/rdata/rresp stable until it does.
//
// Optional build macro IMEM_RAND_DELAY_EN: adds 0..7 pseudo-random extra
// wait cycles per request (from lfsr8). Undefined: fixed LATENCY delay.
module imem_rd_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid_i,
  input  logic [31:0] araddr_i,
  output logic        arready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  input  logic        rready_i,
  input  logic        bd_wen_i,
  input  logic [31:0] bd_waddr_i,
  input  logic [31:0] bd_wdata_i
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  LAT8 = 8'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      aresp_q, aresp_d;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;

  logic            ar_hs;
  logic            enter_resp;
  logic [AW-1:0]   rd_idx;
  logic [1:0]      rd_resp;
  logic [31:0]     ar_off, bd_off;
  logic [AW-1:0]   ar_idx;
  logic [1:0]      ar_resp;
  logic [7:0]      delay_load;

  assign ar_off  = araddr_i - ADDR_BASE;
  assign ar_idx  = ar_off[AW+1:2];
  assign ar_resp = decode_resp(araddr_i, ADDR_BASE, SPAN);
  assign bd_off  = bd_waddr_i - ADDR_BASE;
  assign ar_hs   = arvalid_i && arready_o;

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_val;
  lfsr8 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .en_i   (1'b1),
    .lfsr_o (lfsr_val)
  );
  assign delay_load = LAT8 + {5'd0, lfsr_val[2:0]};
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_val[7:3];
`else
  assign delay_load = LAT8;
`endif

  logic unused_off;
  assign unused_off = ^{ar_off[31:AW+2], ar_off[1:0], bd_off[31:AW+2], bd_off[1:0]};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      aresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      aresp_q <= aresp_d;
    end
  end

  // Next-state logic. rd_idx/rd_resp select the request being entered into
  // RESP: the live AR values on a zero-delay accept, else the latched ones.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    aresp_d    = aresp_q;
    enter_resp = 1'b0;
    rd_idx     = idx_q;
    rd_resp    = aresp_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          idx_d   = ar_idx;
          aresp_d = ar_resp;
          rd_idx  = ar_idx;
          rd_resp = ar_resp;
          if (delay_load == 8'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = delay_load;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    arready_o = (state_q == IDLE) && !reset;
    rvalid_o  = (state_q == RESP);
    rdata_o   = rdata_q;
    rresp_o   = rresp_q;
  end

  // R payload captured once on entry to RESP; a same-edge backdoor write
  // lands after this read, so the old word is returned.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (enter_resp) begin
      rresp_q <= rd_resp;
      rdata_q <= (rd_resp == RESP_OKAY) ? mem[rd_idx] : 32'd0;
    end
  end

  // Backdoor write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (bd_wen_i && (decode_resp({bd_waddr_i[31:2], 2'b00}, ADDR_BASE, SPAN) == RESP_OKAY))
      mem[bd_off[AW+1:2]] <= bd_wdata_i;
  end

endmodule

// File: tb/tb_imem_rd_responder.sv
module tb_imem_rd_responder;

  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid_i = 1'b0;
  logic [31:0] araddr_i = 32'd0;
  logic        arready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rready_i = 1'b0;
  logic        bd_wen_i = 1'b0;
  logic [31:0] bd_waddr_i = 32'd0;
  logic [31:0] bd_wdata_i = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  imem_rd_responder #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .LATENCY     (LATENCY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .arvalid_i  (arvalid_i),
    .araddr_i   (araddr_i),
    .arready_o  (arready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rresp_o    (rresp_o),
    .rready_i   (rready_i),
    .bd_wen_i   (bd_wen_i),
    .bd_waddr_i (bd_waddr_i),
    .bd_wdata_i (bd_wdata_i)
  );

  // Clock
  always #5 clock = ~clock;

  // Driver tasks (inputs change on negedge, outputs sampled on negedge)
  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    bd_wen_i = 1'b1; bd_waddr_i = addr; bd_wdata_i = data;
    @(negedge clock);
    bd_wen_i = 1'b0;
  endtask

  // Issues one AR; lat = cycles from the handshake cycle to the first rvalid
  // cycle (-1 on timeout). Returns at the negedge of that first rvalid cycle.
  task automatic do_read(input logic [31:0] addr, input logic rr,
                         output int lat, output logic [31:0] data,
                         output logic [1:0] resp);
    int guard;
    @(negedge clock);
    araddr_i = addr; arvalid_i = 1'b1; rready_i = rr;
    guard = 0;
    while (!arready_o && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    lat = 0;
    while (lat < 50) begin
      @(negedge clock);
      arvalid_i = 1'b0;
      lat++;
      if (rvalid_o) break;
    end
    if (!rvalid_o) lat = -1;
    data = rdata_o;
    resp = rresp_o;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (arready_o !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b want 0", arready_o); end
    n_checks++;
    if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
    n_checks++;
    if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    n_checks++;
    if (rresp_o !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b want 00", rresp_o); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_arready: got %b want 1", arready_o); end
  endtask

  task automatic test_preload;
    bd_write(32'h8000_0000, 32'hDEAD_BEEF);
    bd_write(32'h8000_0004, 32'h1234_5678);
    bd_write(32'h8000_0008, 32'hA5A5_0001);
    bd_write(32'h8000_3FFC, 32'hCAFE_F00D);
    // Out-of-range writes whose offsets alias word 0 / the last word.
    bd_write(32'h8000_4000, 32'h0BAD_0000);
    bd_write(32'h7FFF_FFFC, 32'h0BAD_FFFF);
  endtask

  task automatic test_okay;
    int lat; logic [31:0] d; logic [1:0] r;
    do_read(32'h8000_0000, 1'b1, lat, d, r);
    n_checks++;
    if (lat !== LATENCY + 1) begin n_fail++; $display("FAIL okay_latency: got %0d want %0d", lat, LATENCY + 1); end
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL okay_rdata: got %h want deadbeef", d); end
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL okay_rresp: got %b want 00", r); end
    @(negedge clock);
    n_checks++;
    if (arready_o !== 1'b1 || rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL okay_return_idle: arready %b rvalid %b want 1 0", arready_o, rvalid_o);
    end
  endtask

  task automatic test_decode;
    logic [31:0] addrs [6];
    logic [31:0] exp_d [6];
    logic [1:0]  exp_r [6];
    int lat; logic [31:0] d; logic [1:0] r;
    addrs[0] = 32'h7FFF_FFFC; exp_d[0] = 32'd0;          exp_r[0] = 2'b11;
    addrs[1] = 32'h8000_4000; exp_d[1] = 32'd0;          exp_r[1] = 2'b11;
    addrs[2] = 32'h8000_3FFC; exp_d[2] = 32'hCAFE_F00D;  exp_r[2] = 2'b00;
    addrs[3] = 32'h8000_0002; exp_d[3] = 32'd0;          exp_r[3] = 2'b10;
    addrs[4] = 32'h8000_0004; exp_d[4] = 32'h1234_5678;  exp_r[4] = 2'b00;
    addrs[5] = 32'h8000_4001; exp_d[5] = 32'd0;          exp_r[5] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      do_read(addrs[i], 1'b1, lat, d, r);
      n_checks++;
      if (lat !== LATENCY + 1) begin n_fail++; $display("FAIL decode_latency[%0d]: got %0d want %0d", i, lat, LATENCY + 1); end
      n_checks++;
      if (r !== exp_r[i]) begin n_fail++; $display("FAIL decode_rresp[%0d]: got %b want %b", i, r, exp_r[i]); end
      n_checks++;
      if (d !== exp_d[i]) begin n_fail++; $display("FAIL decode_rdata[%0d]: got %h want %h", i, d, exp_d[i]); end
    end
    // Aliased out-of-range preload writes must not have landed.
    do_read(32'h8000_0000, 1'b1, lat, d, r);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bd_range_low: got %h want deadbeef", d); end
  endtask

  task automatic test_hold;
    int lat; logic [31:0] d; logic [1:0] r; logic bad;
    do_read(32'h8000_0004, 1'b0, lat, d, r);
    n_checks++;
    if (lat !== LATENCY + 1 || d !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_first: lat %0d data %h want %0d 12345678", lat, d, LATENCY + 1);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234_5678 || rresp_o !== 2'b00 || arready_o !== 1'b0) bad = 1'b1;
      arvalid_i = i[0];
      araddr_i  = 32'h8000_0000;
      @(negedge clock);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL hold_stable: got unstable beat want stable 12345678/00"); end
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    @(negedge clock);
    n_checks++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: rvalid %b arready %b want 0 1", rvalid_o, arready_o);
    end
    bad = 1'b0;
    repeat (6) begin
      if (rvalid_o !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL hold_no_queue: got rvalid 1 want 0"); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic [1:0] r; logic bad;
    @(negedge clock);
    rready_i = 1'b1; araddr_i = 32'h8000_0000; arvalid_i = 1'b1;
    @(negedge clock);
    arvalid_i = 1'b0; reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_arready: got %b want 1", arready_o); end
    bad = 1'b0;
    repeat (8) begin
      if (rvalid_o !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midreset_dropped: got rvalid 1 want 0"); end
    do_read(32'h8000_0004, 1'b1, lat, d, r);
    n_checks++;
    if (lat !== LATENCY + 1 || d !== 32'h1234_5678 || r !== 2'b00) begin
      n_fail++; $display("FAIL midreset_after: lat %0d data %h resp %b want %0d 12345678 00", lat, d, r, LATENCY + 1);
    end
  endtask

  task automatic test_collision;
    int lat; logic [31:0] d; logic [1:0] r;
    @(negedge clock);
    rready_i = 1'b1; araddr_i = 32'h8000_0008; arvalid_i = 1'b1;  // cycle T
    @(negedge clock);
    arvalid_i = 1'b0;                                             // T+1
    @(negedge clock);
    bd_wen_i = 1'b1; bd_waddr_i = 32'h8000_0008; bd_wdata_i = 32'h5EED_0002; // T+2
    @(negedge clock);
    bd_wen_i = 1'b0;                                              // T+3
    n_checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL collision_old: rvalid %b data %h want 1 a5a50001", rvalid_o, rdata_o);
    end
    do_read(32'h8000_0008, 1'b1, lat, d, r);
    n_checks++;
    if (d !== 32'h5EED_0002) begin n_fail++; $display("FAIL collision_new: got %h want 5eed0002", d); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] d; logic [1:0] r;
    logic [31:0] exp_q [$];
    exp_q = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h5EED_0002, 32'hCAFE_F00D};
    for (int i = 0; i < 4; i++) begin
      do_read((i == 3) ? 32'h8000_3FFC : 32'h8000_0000 + 32'(i * 4), 1'b1, lat, d, r);
      n_checks++;
      if (lat !== LATENCY + 1 || d !== exp_q[i] || r !== 2'b00) begin
        n_fail++; $display("FAIL b2b[%0d]: lat %0d data %h resp %b want %0d %h 00", i, lat, d, r, LATENCY + 1, exp_q[i]);
      end
    end
  endtask

`ifdef IMEM_RAND_DELAY_EN
  task automatic test_rand_delay;
    int lat; logic [31:0] d; logic [1:0] r;
    bit seen [16];
    int distinct; logic bad;
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hDEAD_BEEF; exp_d[1] = 32'h1234_5678;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      do_read(32'h8000_0000 + 32'((i % 2) * 4), 1'b1, lat, d, r);
      if (lat < LATENCY + 1 || lat > LATENCY + 8 || d !== exp_d[i % 2]) bad = 1'b1;
      else seen[lat] = 1'b1;
    end
    distinct = 0;
    for (int k = 0; k < 16; k++) if (seen[k]) distinct++;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL rand_range: got out-of-range delay or bad data want %0d..%0d", LATENCY, LATENCY + 7); end
    n_checks++;
    if (distinct < 4) begin n_fail++; $display("FAIL rand_distinct: got %0d want >=4", distinct); end
  endtask
`endif

  initial begin
    test_reset;
    test_preload;
    test_okay;
    test_decode;
    test_hold;
    test_reset_mid;
    test_collision;
    test_back_to_back;
`ifdef IMEM_RAND_DELAY_EN
    test_rand_delay;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
